// File: rtl/safe_stack_mc_pkg.sv
// Shared op codes and response error codes for the multi-context safe stack.
package safe_stack_mc_pkg;

    localparam logic [7:0] SS_OP_NOP   = 8'd0;
    localparam logic [7:0] SS_OP_PUSH  = 8'd1;
    localparam logic [7:0] SS_OP_POP   = 8'd2;
    localparam logic [7:0] SS_OP_PEEK  = 8'd3;
    localparam logic [7:0] SS_OP_CLEAR = 8'd4;
    localparam logic [7:0] SS_OP_DEPTH = 8'd5;

    typedef enum logic [1:0] {
        SS_ERR_OK  = 2'b00,
        SS_ERR_OVF = 2'b01,
        SS_ERR_UNF = 2'b10,
        SS_ERR_ILL = 2'b11
    } ss_err_e;

endpackage

// File: rtl/safe_stack_mc_ram.sv
// Simple dual-port stack storage: synchronous write, synchronous read with read enable.
// The read register holds its value while re is low, which keeps a stalled response stable.
module safe_stack_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/safe_stack_mc.sv
// Multi-context hardware safe stack: per-context pointers, op decode, a single-slot
// response register and a sticky fault flag, backed by one shared RAM addressed {ctx, entry}.
module safe_stack_mc
    import safe_stack_mc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int CTX_NUM = 4,
    parameter int CTX_W   = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_op,
    input  logic [CTX_W-1:0]  req_ctx,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              fault,
    input  logic              fault_clr
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]  ptr [CTX_NUM];
    logic [PTR_W-1:0]  cur_ptr;
    logic [PTR_W-1:0]  ptr_dec;
    logic [PTR_W-1:0]  nxt_ptr;
    logic              ptr_we;
    logic [AW-1:0]     entry;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;
    ss_err_e           nxt_err;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_from_ram;
    ss_err_e           rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_from_ram;

    assign req_ready = ~rsp_valid | rsp_ready;
    assign accept    = req_valid & req_ready & resetn;
    assign ptr_dec   = cur_ptr - PTR_W'(1);

    always_comb begin
        cur_ptr      = ptr[req_ctx];
        nxt_ptr      = cur_ptr;
        ptr_we       = 1'b0;
        entry        = cur_ptr[AW-1:0];
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        nxt_err      = SS_ERR_OK;
        nxt_data     = '0;
        nxt_from_ram = 1'b0;
        case (req_op)
            SS_OP_NOP: begin
            end
            SS_OP_PUSH: begin
                if (cur_ptr == PTR_W'(DEPTH)) begin
                    nxt_err = SS_ERR_OVF;
                end else begin
                    ram_we  = accept;
                    nxt_ptr = cur_ptr + PTR_W'(1);
                    ptr_we  = 1'b1;
                end
            end
            SS_OP_POP, SS_OP_PEEK: begin
                if (cur_ptr == '0) begin
                    nxt_err = SS_ERR_UNF;
                end else begin
                    // Read data comes straight from the RAM output register one cycle later
                    entry        = ptr_dec[AW-1:0];
                    ram_re       = accept;
                    nxt_from_ram = 1'b1;
                    if (req_op == SS_OP_POP) begin
                        nxt_ptr = ptr_dec;
                        ptr_we  = 1'b1;
                    end
                end
            end
            SS_OP_CLEAR: begin
                nxt_data = DATA_W'(cur_ptr);
                nxt_ptr  = '0;
                ptr_we   = 1'b1;
            end
            SS_OP_DEPTH: begin
                nxt_data = DATA_W'(cur_ptr);
            end
            default: begin
                nxt_err = SS_ERR_ILL;
            end
        endcase
    end

    safe_stack_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(CTX_W + AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr({req_ctx, entry}),
        .wdata(req_wdata),
        .re   (ram_re),
        .raddr({req_ctx, entry}),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < CTX_NUM; i++) begin
                ptr[i] <= '0;
            end
            rsp_valid    <= 1'b0;
            rsp_err_q    <= SS_ERR_OK;
            rsp_data_q   <= '0;
            rsp_from_ram <= 1'b0;
            fault        <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid    <= 1'b1;
                rsp_err_q    <= nxt_err;
                rsp_data_q   <= nxt_data;
                rsp_from_ram <= nxt_from_ram;
                if (ptr_we) begin
                    ptr[req_ctx] <= nxt_ptr;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // A new error outranks a simultaneous clear request
            if (accept && (nxt_err != SS_ERR_OK)) begin
                fault <= 1'b1;
            end else if (fault_clr) begin
                fault <= 1'b0;
            end
        end
    end

    assign rsp_rdata = rsp_from_ram ? ram_rdata : rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_safe_stack_mc.sv
// Scoreboard bench for safe_stack_mc: directed scenarios then random traffic, checked
// against an array-based LIFO model with a decoupled response monitor.
module tb_safe_stack_mc;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int CTX_NUM = 4;
    localparam int CTX_W   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [CTX_W-1:0]  req_ctx;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_err;
    logic              fault;
    logic              fault_clr;

    int          compared   = 0;
    int          mismatched = 0;
    exp_t        exp_q [$];
    logic        exp_fault = 1'b0;
    int          cnt_m [CTX_NUM];
    logic [31:0] mem_m [CTX_NUM][DEPTH];

    safe_stack_mc #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CTX_NUM(CTX_NUM), .CTX_W(CTX_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ctx(req_ctx), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // LIFO reference: each context is an array plus an occupancy count.
    task automatic model_apply(input logic [7:0] op, input int c, input logic [31:0] w,
                               output exp_t e);
        e.rdata = 32'd0;
        e.err   = 2'b00;
        case (op)
            8'd0: ;
            8'd1: if (cnt_m[c] == DEPTH) e.err = 2'b01;
                  else begin mem_m[c][cnt_m[c]] = w; cnt_m[c]++; end
            8'd2: if (cnt_m[c] == 0) e.err = 2'b10;
                  else begin e.rdata = mem_m[c][cnt_m[c]-1]; cnt_m[c]--; end
            8'd3: if (cnt_m[c] == 0) e.err = 2'b10;
                  else e.rdata = mem_m[c][cnt_m[c]-1];
            8'd4: begin e.rdata = 32'(cnt_m[c]); cnt_m[c] = 0; end
            8'd5: e.rdata = 32'(cnt_m[c]);
            default: e.err = 2'b11;
        endcase
    endtask

    // One clock cycle: decide acceptance mid-cycle, then track fault and reset effects.
    task automatic step(output logic accepted);
        exp_t e;
        logic set_f;
        @(negedge clk);
        accepted = req_valid && req_ready && resetn;
        set_f    = 1'b0;
        if (accepted) begin
            model_apply(req_op, int'(req_ctx), req_wdata, e);
            exp_q.push_back(e);
            set_f = (e.err != 2'b00);
        end
        @(posedge clk);
        #1;
        if (!resetn) begin
            exp_q.delete();
            exp_fault = 1'b0;
            for (int c = 0; c < CTX_NUM; c++) cnt_m[c] = 0;
        end else if (set_f) begin
            exp_fault = 1'b1;
        end else if (fault_clr) begin
            exp_fault = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input int c, input logic [31:0] w,
                                  input logic clr, input int ready_pct);
        logic acc;
        int   tries = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_ctx   = CTX_W'(c);
        req_wdata = w;
        fault_clr = clr;
        do begin
            rsp_ready = ($urandom_range(99) < ready_pct);
            step(acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) check_output("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic idle(input int n, input logic ready);
        logic acc;
        req_valid = 1'b0;
        rsp_ready = ready;
        repeat (n) step(acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        resetn    = 1'b0;
        req_valid = 1'b0;
        repeat (n) step(acc);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_output("reset_fault", 32'(fault), 32'd0);
        resetn = 1'b1;
        check_output("ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    // Monitor: compares the head of the scoreboard for every cycle a response is shown.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            check_output("fault_flag", 32'(fault), 32'(exp_fault));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    check_output("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    check_output("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic acc;
        int   r;
        req_valid = 1'b0; req_op = 8'd0; req_ctx = '0; req_wdata = '0;
        rsp_ready = 1'b1; fault_clr = 1'b0; resetn = 1'b0;
        for (int c = 0; c < CTX_NUM; c++) cnt_m[c] = 0;
        do_reset(2);

        $display("[TB] basic push/pop on ctx0");
        apply_stimulus(8'd1, 0, 32'hA5A5_0001, 1'b0, 100);
        apply_stimulus(8'd1, 0, 32'hA5A5_0002, 1'b0, 100);
        apply_stimulus(8'd2, 0, 32'd0, 1'b0, 100);
        apply_stimulus(8'd2, 0, 32'd0, 1'b0, 100);

        $display("[TB] fill ctx1 to overflow");
        for (int i = 0; i < DEPTH; i++) apply_stimulus(8'd1, 1, $urandom, 1'b0, 100);
        apply_stimulus(8'd1, 1, 32'hDEAD_BEEF, 1'b0, 100);
        apply_stimulus(8'd5, 1, 32'd0, 1'b0, 100);
        apply_stimulus(8'd2, 1, 32'd0, 1'b0, 100);
        idle(1, 1'b1);
        check_output("fault_after_ovf", 32'(fault), 32'd1);
        apply_stimulus(8'd0, 0, 32'd0, 1'b1, 100);

        $display("[TB] underflow on ctx2 with concurrent clear");
        apply_stimulus(8'd2, 2, 32'd0, 1'b0, 100);
        apply_stimulus(8'd3, 2, 32'd0, 1'b1, 100);
        idle(1, 1'b1);
        check_output("fault_set_wins", 32'(fault), 32'd1);

        $display("[TB] interleaved ctx0/ctx3");
        apply_stimulus(8'd1, 0, 32'h11, 1'b0, 100);
        apply_stimulus(8'd1, 3, 32'h33, 1'b0, 100);
        apply_stimulus(8'd1, 0, 32'h12, 1'b0, 100);
        apply_stimulus(8'd2, 3, 32'd0, 1'b0, 100);
        apply_stimulus(8'd2, 0, 32'd0, 1'b0, 100);

        $display("[TB] backpressure hold and illegal op");
        apply_stimulus(8'd3, 0, 32'd0, 1'b0, 100);
        req_valid = 1'b1; req_op = 8'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check_output("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        apply_stimulus(8'h07, 0, 32'd0, 1'b0, 100);

        $display("[TB] clear, empty pop, mid-stream reset");
        apply_stimulus(8'd4, 0, 32'd0, 1'b0, 100);
        for (int i = 0; i < 3; i++) apply_stimulus(8'd1, 0, 32'h100 + 32'(i), 1'b0, 100);
        apply_stimulus(8'd4, 0, 32'd0, 1'b0, 100);
        apply_stimulus(8'd2, 0, 32'd0, 1'b0, 100);
        apply_stimulus(8'd1, 0, 32'h5555, 1'b0, 100);
        idle(1, 1'b0);
        do_reset(1);
        apply_stimulus(8'd5, 0, 32'd0, 1'b0, 100);

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(99);
            if (n % 400 == 399) do_reset(1);
            apply_stimulus((r < 40) ? 8'd1 : (r < 62) ? 8'd2 : (r < 72) ? 8'd3 :
                           (r < 75) ? 8'd4 : (r < 85) ? 8'd5 : (r < 91) ? 8'd0 :
                           8'($urandom_range(255, 6)),
                           int'($urandom_range(CTX_NUM - 1)), $urandom,
                           ($urandom_range(7) == 0), 75);
        end
        idle(4, 1'b1);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
